// File: rtl/mux_rr_stream.sv
// mux_rr_stream: NCH-to-1 stream selector with manual or round-robin grant
// and a single registered output stage using valid/ready handshaking.
module mux_rr_stream #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [NCH-1:0]       i_valid,
    output logic [NCH-1:0]       o_ready,
    input  logic                 i_mode,
    input  logic [SEL_W-1:0]     i_con,
    output logic [WIDTH-1:0]     o_data,
    output logic [SEL_W-1:0]     o_chan,
    output logic                 o_valid,
    input  logic                 i_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]   chan_q;
    logic [SEL_W-1:0]   ptr_q;

    logic               load_en;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   cand;
    logic [WIDTH-1:0]   sel_data;
    logic               xfer;

    // The stage can accept a word when empty or when it drains this cycle.
    assign load_en = (state_q == EMPTY) || i_ready;

    // Grant: explicit select in manual mode, otherwise first valid channel
    // after the last winner, wrapping modulo NCH.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!i_mode) begin
            if (int'(i_con) < NCH) begin
                grant_vld = 1'b1;
                grant_idx = i_con;
            end
        end else begin
            for (int off = 1; off <= NCH; off++) begin
                cand = SEL_W'((int'(ptr_q) + off) % NCH);
                if (!grant_vld && i_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Route the granted channel's data toward the output register.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                sel_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready to the granted channel, suppressed during reset.
    always_comb begin
        o_ready = '0;
        if (load_en && grant_vld && !i_rst) begin
            o_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(i_valid & o_ready);

    // Output-stage next state: load wins over drain, drain empties the stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            FULL:    if (xfer) state_d = FULL;
                     else if (i_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output register, channel tag and round-robin pointer.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            ptr_q   <= SEL_W'(NCH - 1);
        end else begin
            state_q <= state_d;
            if (xfer) begin
                data_q <= sel_data;
                chan_q <= grant_idx;
                ptr_q  <= grant_idx;
            end
        end
    end

    assign o_data  = data_q;
    assign o_chan  = chan_q;
    assign o_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_rr_stream.sv
// Testbench for mux_rr_stream: directed scenarios with literal expectations
// plus a randomized run against a cycle-level transaction model.
module tb_mux_rr_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        mode;
    logic [1:0]  con;
    logic        in_ready;

    logic [3:0]  ready4;
    logic [7:0]  odata4;
    logic [1:0]  ochan4;
    logic        ovalid4;

    logic [2:0]  ready3;
    logic [7:0]  odata3;
    logic [1:0]  ochan3;
    logic        ovalid3;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: contents of the output stage and last granted channel.
    bit       m_valid;
    logic [7:0] m_data;
    int       m_chan;
    int       m_ptr;

    always #5 clk = ~clk;

    mux_rr_stream #(.WIDTH(8), .NCH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
        .o_ready(ready4), .i_mode(mode), .i_con(con), .o_data(odata4),
        .o_chan(ochan4), .o_valid(ovalid4), .i_ready(in_ready)
    );

    mux_rr_stream #(.WIDTH(8), .NCH(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_data(data[23:0]), .i_valid(valid[2:0]),
        .o_ready(ready3), .i_mode(mode), .i_con(con), .o_data(odata3),
        .o_chan(ochan3), .o_valid(ovalid3), .i_ready(in_ready)
    );

    // Channel to be granted this cycle for the 4-channel instance, or -1.
    function automatic int model_grant();
        if (!mode) return int'(con);
        for (int off = 1; off <= 4; off++) begin
            if (valid[(m_ptr + off) % 4]) return (m_ptr + off) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = model_grant();
        if (rst || g < 0 || !(!m_valid || in_ready)) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // Advance one clock, updating the model with the inputs seen at the edge.
    task automatic cycle();
        int g;
        logic [3:0] er;
        g  = model_grant();
        er = model_ready();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_chan = 0; m_ptr = 3;
        end else if (er != 4'b0000 && valid[g]) begin
            m_valid = 1; m_data = data[g*8 +: 8]; m_chan = g; m_ptr = g;
        end else if (in_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic set_default_data();
        data = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_default_data();
        valid = 4'hF; in_ready = 1'b1; mode = 1'b1; con = 2'd0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (ready4 !== 4'b0000 || ready3 !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_ready: got %b/%b want 0000/000", ready4, ready3);
            end
            cycle();
            tests_run++;
            if (ovalid4 !== 1'b0 || odata4 !== 8'h00 || ochan4 !== 2'd0) begin
                tests_failed++;
                $display("FAIL reset_out: got v=%b d=%h c=%0d want v=0 d=00 c=0",
                         ovalid4, odata4, ochan4);
            end
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (ready4 !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant_ready: got %b want 0001", ready4);
        end
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b1 || ochan4 !== 2'd0 || odata4 !== 8'h10) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got v=%b c=%0d d=%h want v=1 c=0 d=10",
                     ovalid4, ochan4, odata4);
        end
    endtask

    task automatic test_rr_fairness();
        set_default_data();
        mode = 1'b1; valid = 4'hF; in_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            #1;
            tests_run++;
            if (ready4 !== 4'(1 << (k % 4))) begin
                tests_failed++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, ready4, 4'(1 << (k % 4)));
            end
            cycle();
            tests_run++;
            if (ovalid4 !== 1'b1 || ochan4 !== 2'(k % 4) || odata4 !== 8'(8'h10 + k % 4)) begin
                tests_failed++;
                $display("FAIL rr_fair[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, ovalid4, ochan4, odata4, k % 4, 8'h10 + k % 4);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_ch [7] = '{1, 3, 1, 3, 3, 3, 3};
        set_default_data();
        mode = 1'b1; valid = 4'b1010; in_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k == 4) valid = 4'b1000;
            cycle();
            tests_run++;
            if (ovalid4 !== 1'b1 || ochan4 !== 2'(exp_ch[k]) || odata4 !== 8'(8'h10 + exp_ch[k])) begin
                tests_failed++;
                $display("FAIL rr_sparse[%0d]: got v=%b c=%0d d=%h want v=1 c=%0d d=%h",
                         k, ovalid4, ochan4, odata4, exp_ch[k], 8'h10 + exp_ch[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        set_default_data();
        mode = 1'b1; valid = 4'b0100; in_ready = 1'b1;
        do_reset();
        cycle();
        in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            data = $urandom; valid = 4'($urandom); mode = 1'($urandom); con = 2'($urandom);
            #1;
            tests_run++;
            if (ready4 !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready[%0d]: got %b want 0000", k, ready4);
            end
            cycle();
            tests_run++;
            if (ovalid4 !== 1'b1 || odata4 !== 8'h12 || ochan4 !== 2'd2) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h c=%0d want v=1 d=12 c=2",
                         k, ovalid4, odata4, ochan4);
            end
        end
        set_default_data();
        mode = 1'b1; valid = 4'b1000; in_ready = 1'b1;
        #1;
        tests_run++;
        if (ready4 !== 4'b1000) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want 1000", ready4);
        end
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b1 || odata4 !== 8'h13 || ochan4 !== 2'd3) begin
            tests_failed++;
            $display("FAIL bp_release_load: got v=%b d=%h c=%0d want v=1 d=13 c=3",
                     ovalid4, odata4, ochan4);
        end
    endtask

    task automatic test_manual();
        set_default_data();
        mode = 1'b0; con = 2'd3; valid = 4'hF; in_ready = 1'b1;
        do_reset();
        #1;
        tests_run++;
        if (ready3 !== 3'b000) begin
            tests_failed++;
            $display("FAIL manual_oob_ready: got %b want 000", ready3);
        end
        cycle();
        tests_run++;
        if (ovalid3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL manual_oob_load: got v=%b want 0", ovalid3);
        end
        do_reset();
        con = 2'd2; valid = 4'b0100; data[23:16] = 8'hA5;
        #1;
        tests_run++;
        if (ready4 !== 4'b0100) begin
            tests_failed++;
            $display("FAIL manual_ready: got %b want 0100", ready4);
        end
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b1 || odata4 !== 8'hA5 || ochan4 !== 2'd2) begin
            tests_failed++;
            $display("FAIL manual_load: got v=%b d=%h c=%0d want v=1 d=a5 c=2",
                     ovalid4, odata4, ochan4);
        end
        valid = 4'b1011;
        #1;
        tests_run++;
        if (ready4 !== 4'b0100) begin
            tests_failed++;
            $display("FAIL manual_ready_no_valid: got %b want 0100", ready4);
        end
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b0 || odata4 !== 8'hA5 || ochan4 !== 2'd2) begin
            tests_failed++;
            $display("FAIL manual_drain: got v=%b d=%h c=%0d want v=0 d=a5 c=2",
                     ovalid4, odata4, ochan4);
        end
    endtask

    task automatic test_reset_mid();
        set_default_data();
        mode = 1'b1; valid = 4'b1000; in_ready = 1'b1;
        do_reset();
        cycle();
        in_ready = 1'b0;
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b1 || odata4 !== 8'h13) begin
            tests_failed++;
            $display("FAIL mid_setup: got v=%b d=%h want v=1 d=13", ovalid4, odata4);
        end
        rst = 1'b1;
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b0 || odata4 !== 8'h00 || ochan4 !== 2'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b d=%h c=%0d want v=0 d=00 c=0",
                     ovalid4, odata4, ochan4);
        end
        rst = 1'b0; valid = 4'hF; in_ready = 1'b1;
        cycle();
        tests_run++;
        if (ovalid4 !== 1'b1 || ochan4 !== 2'd0 || odata4 !== 8'h10) begin
            tests_failed++;
            $display("FAIL mid_restart: got v=%b c=%0d d=%h want v=1 c=0 d=10",
                     ovalid4, ochan4, odata4);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int n = 0; n < 400; n++) begin
            data     = $urandom;
            valid    = 4'($urandom);
            mode     = 1'($urandom);
            con      = 2'($urandom);
            in_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 39) == 0);
            #1;
            er = model_ready();
            tests_run++;
            if (ready4 !== er) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, ready4, er);
            end
            cycle();
            tests_run++;
            if (ovalid4 !== m_valid || odata4 !== m_data || ochan4 !== 2'(m_chan)) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         n, ovalid4, odata4, ochan4, m_valid, m_data, m_chan);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_valid = 0; m_data = 8'h00; m_chan = 0; m_ptr = 3;
        rst = 1'b1; data = '0; valid = '0; mode = 1'b1; con = '0; in_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_rr_fairness();
        test_rr_sparse();
        test_back_pressure();
        test_manual();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
